// File: rtl/buf_mem_responder.sv
// Buffer-memory responder behind the NPU buffer access interface.
// Engine reads return after a fixed MEM_DELAY latency. Engine writes commit in
// the same cycle. A low-priority host port uses the slots the engine leaves idle.
// Host reads share the engine read pipeline and carry a tag that routes them
// to the host outputs.
module buf_mem_responder #(
  parameter int AW         = 16,
  parameter int BUFFD      = 64,
  parameter int DEPTH      = 1024,
  parameter int MEM_DELAY  = 8,
  parameter int STARVE_LIM = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic [AW-1:0]        raddr,
  input  logic                 raddr_vld,
  output logic [BUFFD*8-1:0]   rdata,
  output logic                 rdata_vld,
  input  logic [AW-1:0]        waddr,
  input  logic [BUFFD*8-1:0]   wdata,
  input  logic                 wdata_vld,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [AW-1:0]        host_addr,
  input  logic [BUFFD*8-1:0]   host_wdata,
  output logic                 host_gnt,
  output logic [BUFFD*8-1:0]   host_rdata,
  output logic                 host_rvld,
  output logic [AW-1:0]        rd_cnt,
  output logic [AW-1:0]        wr_cnt,
  output logic                 oob_err,
  output logic                 host_starve
);

  localparam int DW   = BUFFD * 8;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Stages between the array read and the output registers.
  localparam int NS   = MEM_DELAY - 1;
  localparam int SW   = (NS > 0) ? NS : 1;
  localparam int LAST = SW - 1;
  localparam int CW   = $clog2(STARVE_LIM + 1);

  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] STARVE_X = CW'(STARVE_LIM);

  localparam logic [0:0] HIDLE = 1'b0;
  localparam logic [0:0] HWAIT = 1'b1;

  // The array has no reset, so its contents are undefined after power-up.
  logic [DW-1:0] mem [DEPTH];

  logic          r_oob, w_oob, h_oob;
  logic          host_rd_gnt, host_wr_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          rd_fire, rd_host, rd_oob;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_word;

  logic          pipe_vld_d  [SW];
  logic          pipe_vld_q  [SW];
  logic          pipe_host_d [SW];
  logic          pipe_host_q [SW];
  logic [DW-1:0] pipe_data_d [SW];
  logic [DW-1:0] pipe_data_q [SW];

  logic          last_vld, last_host;
  logic [DW-1:0] last_data;

  logic          rdata_vld_d, rdata_vld_q;
  logic [DW-1:0] rdata_d, rdata_q;
  logic          host_rvld_d, host_rvld_q;
  logic [DW-1:0] host_rdata_d, host_rdata_q;

  logic          denied, oob_now;
  logic [0:0]    state_d, state_q;
  logic [CW-1:0] deny_cnt_d, deny_cnt_q;
  logic          host_starve_d, host_starve_q;
  logic          oob_err_d, oob_err_q;
  logic [AW-1:0] rd_cnt_d, rd_cnt_q;
  logic [AW-1:0] wr_cnt_d, wr_cnt_q;

  // Decode range checks, grant the host only into idle slots, and steer the
  // shared read and write ports.
  always_comb begin
    r_oob       = ({1'b0, raddr} >= DEPTH_X);
    w_oob       = ({1'b0, waddr} >= DEPTH_X);
    h_oob       = ({1'b0, host_addr} >= DEPTH_X);
    host_rd_gnt = host_req & ~host_we & ~raddr_vld;
    host_wr_gnt = host_req & host_we & ~wdata_vld;
    host_gnt    = host_rd_gnt | host_wr_gnt;
    mem_we      = wdata_vld ? ~w_oob : (host_wr_gnt & ~h_oob);
    mem_waddr   = wdata_vld ? waddr : host_addr;
    mem_wdata   = wdata_vld ? wdata : host_wdata;
    rd_fire     = raddr_vld | host_rd_gnt;
    rd_host     = ~raddr_vld;
    rd_addr     = raddr_vld ? raddr : host_addr;
    rd_oob      = raddr_vld ? r_oob : h_oob;
  end

  // Capture the line at issue time. A write to the same line in this cycle is
  // forwarded, so the read returns the new data. Out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (!rd_oob) begin
      if (mem_we && (mem_waddr == rd_addr)) begin
        rd_word = mem_wdata;
      end else begin
        rd_word = mem[rd_addr[IW-1:0]];
      end
    end
  end

  // Array write port, shared by the engine and the granted host writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IW-1:0]] <= mem_wdata;
    end
  end

  // Next-state values for the latency pipeline. Stage 0 takes the new read.
  always_comb begin
    pipe_vld_d[0]  = rd_fire;
    pipe_host_d[0] = rd_host;
    pipe_data_d[0] = rd_word;
    for (int i = 1; i < SW; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_host_d[i] = pipe_host_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  for (genvar gi = 0; gi < NS; gi++) begin : g_stage
    // Advance the valid and tag bits. They clear on reset so in-flight reads are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pipe_vld_q[gi]  <= 1'b0;
        pipe_host_q[gi] <= 1'b0;
      end else begin
        pipe_vld_q[gi]  <= pipe_vld_d[gi];
        pipe_host_q[gi] <= pipe_host_d[gi];
      end
    end

    // Advance the data. It is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
      pipe_data_q[gi] <= pipe_data_d[gi];
    end
  end

  // Select the entry that feeds the output registers. With a latency of 1
  // there are no intermediate stages, so the new read feeds them directly.
  always_comb begin
    if (NS > 0) begin
      last_vld  = pipe_vld_q[LAST];
      last_host = pipe_host_q[LAST];
      last_data = pipe_data_q[LAST];
    end else begin
      last_vld  = rd_fire;
      last_host = rd_host;
      last_data = rd_word;
    end
  end

  // Route the returning entry by its tag. Each data output holds its last
  // value while its valid is low.
  always_comb begin
    rdata_vld_d  = last_vld & ~last_host;
    rdata_d      = rdata_vld_d ? last_data : rdata_q;
    host_rvld_d  = last_vld & last_host;
    host_rdata_d = host_rvld_d ? last_data : host_rdata_q;
  end

  // Host-wait FSM, starvation tracking, access counters and the sticky range error.
  always_comb begin
    denied     = host_req & ~host_gnt;
    state_d    = denied ? HWAIT : HIDLE;
    deny_cnt_d = '0;
    if (denied) begin
      if (state_q == HIDLE) begin
        deny_cnt_d = CW'(1);
      end else if (deny_cnt_q == STARVE_X) begin
        deny_cnt_d = deny_cnt_q;
      end else begin
        deny_cnt_d = deny_cnt_q + CW'(1);
      end
    end
    host_starve_d = host_starve_q | (denied && (deny_cnt_d == STARVE_X));

    oob_now   = (raddr_vld & r_oob) | (wdata_vld & w_oob) | (host_gnt & h_oob);
    oob_err_d = oob_err_q | oob_now;
    rd_cnt_d  = raddr_vld ? rd_cnt_q + AW'(1) : rd_cnt_q;
    wr_cnt_d  = wdata_vld ? wr_cnt_q + AW'(1) : wr_cnt_q;

    // A clear overrides any increment or flag set in the same cycle.
    if (clr) begin
      deny_cnt_d    = '0;
      host_starve_d = 1'b0;
      oob_err_d     = 1'b0;
      rd_cnt_d      = '0;
      wr_cnt_d      = '0;
    end
  end

  // Output and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_vld_q   <= 1'b0;
      rdata_q       <= '0;
      host_rvld_q   <= 1'b0;
      host_rdata_q  <= '0;
      state_q       <= HIDLE;
      deny_cnt_q    <= '0;
      host_starve_q <= 1'b0;
      oob_err_q     <= 1'b0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
    end else begin
      rdata_vld_q   <= rdata_vld_d;
      rdata_q       <= rdata_d;
      host_rvld_q   <= host_rvld_d;
      host_rdata_q  <= host_rdata_d;
      state_q       <= state_d;
      deny_cnt_q    <= deny_cnt_d;
      host_starve_q <= host_starve_d;
      oob_err_q     <= oob_err_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_vld   = rdata_vld_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvld   = host_rvld_q;
  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;
  assign oob_err     = oob_err_q;
  assign host_starve = host_starve_q;

endmodule
